// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int TMO_CNT_W       = 8;
    localparam int ACC_CNT_W       = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts REQ cycles; expired is high during the TIMEOUT_CYC-th enabled cycle.
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: IDLE -> REQ -> DONE handshake with pipeline stall.
// Optional REQ timeout with sticky err_o is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    input  logic                 flush_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 rdata_valid_o,
    output logic                 stall_o,
    output logic                 err_o,
    output logic [ACC_CNT_W-1:0] access_cnt_o
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TMO_CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range");
    end

    state_t state_q;
    logic   start;
    logic   timeout;

    assign start = (MemRead_i | MemWrite_i) & ~flush_i;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (state_q == IDLE && start),
        .enable  (state_q == REQ),
        .expired (timeout)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (state_q == REQ && !mem_ack_i && timeout) begin
            err_o <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Stall is combinational so the pipeline freezes in the detect cycle itself.
    assign stall_o = rst_i & ((state_q == IDLE && start) || state_q == REQ);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, regardless of order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            access_cnt_o  <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= MemWrite_i;
                        mem_req_o   <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // An ack wins over a timeout landing in the same cycle.
                    if (mem_ack_i || timeout) begin
                        mem_req_o    <= 1'b0;
                        access_cnt_o <= access_cnt_o + 1'b1;
                        state_q      <= DONE;
                        if (!mem_we_o) begin
                            rdata_valid_o <= 1'b1;
                            rdata_o       <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT_CYC, default 16, maximum REQ cycles before timeout (range 1..255).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 MemRead_i  in  1  MEM-stage load request from the pipeline.
REQ-007 MemWrite_i  in  1  MEM-stage store request from the pipeline.
REQ-008 flush_i  in  1  MEM-stage instruction squashed; suppresses a new access.
REQ-009 addr_i  in  ADDR_W  access address (ALU result).
REQ-010 wdata_i  in  DATA_W  store data.
REQ-011 mem_req_o  out  1  memory request, held until mem_ack_i.
REQ-012 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o is high.
REQ-013 mem_addr_o / mem_wdata_o  out  ADDR_W / DATA_W  latched address and store data.
REQ-014 mem_ack_i  in  1  memory completion, one-cycle pulse.
REQ-015 mem_rdata_i  in  DATA_W  read data; valid with mem_ack_i.
REQ-016 rdata_o  out  DATA_W  captured load data; held until the next load completes.
REQ-017 rdata_valid_o  out  1  one-cycle pulse when a load completes.
REQ-018 stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-019 err_o  out  1  sticky timeout flag.
REQ-020 access_cnt_o  out  16  count of completed accesses; wraps from 0xFFFF to 0.

Function
REQ-021 FSM states: IDLE, REQ, DONE.
REQ-022 IDLE: when (MemRead_i | MemWrite_i) & ~flush_i is true, the block latches addr, wdata and we (we = MemWrite_i), then goes to REQ; stall_o is driven combinationally to 1 in that cycle.
REQ-023 When MemRead_i and MemWrite_i are both high, the write has priority; that is, mem_we_o = 1.
REQ-024 REQ: mem_req_o = 1 and stall_o = 1; the block stays in REQ until mem_ack_i, then goes to DONE.
REQ-025 flush_i during REQ is ignored; an issued access is never aborted.
REQ-026 On ack of a read, rdata_o <= mem_rdata_i; rdata_valid_o is 1 in the DONE cycle.
REQ-027 DONE: stall_o = 0 and mem_req_o = 0; access_cnt_o increments; the next state is always IDLE.
REQ-028 Minimum occupancy with an ack in the first REQ cycle: 3 cycles (IDLE detect, REQ, DONE), with stall_o high for 2 of them.
REQ-029 mem_ack_i outside REQ is ignored.
REQ-030 Mem outputs are registered, with no combinational path from MemRead_i/MemWrite_i to mem_req_o.

Reset
REQ-031 rst_i low forces the following immediately: state IDLE, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, rdata_o 0, rdata_valid_o 0, access_cnt_o 0, err_o 0, timeout counter 0.
REQ-032 While rst_i is low, stall_o = 0.
REQ-033 Reset during REQ drops mem_req_o immediately without waiting for an ack.

Configuration
REQ-034 The macro MEM_TIMEOUT_EN controls the timeout feature.
REQ-035 When MEM_TIMEOUT_EN is defined:
- the timeout counter clears on REQ entry and counts REQ cycles;
- if the count reaches TIMEOUT_CYC without an ack, the block drops mem_req_o, sets err_o (sticky until reset) and goes to DONE;
- on a timed-out load, rdata_o is set to 0 and rdata_valid_o pulses;
- access_cnt_o still increments.
REQ-036 When MEM_TIMEOUT_EN is undefined, REQ waits indefinitely, err_o is tied to 0 and no counter logic exists.

Structure
REQ-037 The shared package mem_ctrl_pkg holds the state enum (IDLE/REQ/DONE), TIMEOUT_CYC default and counter width constants.
REQ-038 The sub-module mem_timeout_cnt (clear, enable, expired output) is instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-039 Load at addr 0x40 with ack in the first REQ cycle, rdata 0xDEADBEEF -> stall_o high 2 cycles, rdata_o = 0xDEADBEEF with rdata_valid_o pulse, access_cnt_o = 1.
REQ-040 Store addr 0x80, wdata 0x12345678, ack delayed 5 cycles -> mem_req_o/mem_we_o held 6 cycles with stable addr/wdata, stall_o high 7 cycles.
REQ-041 MemRead_i with flush_i in IDLE -> no mem_req_o, stall_o 0, count unchanged; flush_i during REQ -> access completes normally.
REQ-042 Two back-to-back loads -> two separate 3-cycle sequences, access_cnt_o = 2; MemRead_i and MemWrite_i both high -> mem_we_o = 1.
REQ-043 With MEM_TIMEOUT_EN and TIMEOUT_CYC = 4, no ack -> mem_req_o drops after 4 cycles, err_o = 1 and stays 1, rdata_o = 0; without the macro -> stall persists and err_o = 0.
REQ-044 rst_i low for 1 cycle mid-REQ -> all outputs go to reset values asynchronously, FSM returns to IDLE, and a late mem_ack_i is ignored.
